display_conv_ctrl: RTL and testbench
====================================

Name: display_conv_ctrl

Overview:
- Sequential controller that shares the four-digit seven-segment display between two value sources.
- Arbitrates requests round-robin and converts the granted binary value to four BCD digits with an iterative shift-add-3 (double dabble) datapath.
- Drives registered segment outputs display0..display3, with display0 as the units digit.
- Sits between result-producing blocks and the board's HEX displays; replaces combinational division-based decoding.

Parameters:
- WIDTH, 10, bit width of val0/val1; legal range 4..13, so the maximum value is always 9999 or less.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- req0  input  1  requester 0 wants its value shown; level, held until ack0
- val0  input  WIDTH  requester 0 value, unsigned
- req1  input  1  requester 1 wants its value shown; level, held until ack1
- val1  input  WIDTH  requester 1 value, unsigned
- ack0  output  1  one-cycle pulse: val0 captured
- ack1  output  1  one-cycle pulse: val1 captured
- busy  output  1  high while a conversion is in progress (LOAD..DONE)
- done  output  1  one-cycle pulse: displays updated this cycle
- src  output  1  requester whose value is currently displayed
- display0  output  7  units digit segments, active-low, {g,f,e,d,c,b,a}
- display1  output  7  tens digit segments
- display2  output  7  hundreds digit segments
- display3  output  7  thousands digit segments

Behaviour:
- Clock and reset: single clock, clk. rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - ack0, ack1, busy, done, src = 0.
  - display0..3 = 7'b0111111 (dash).
  - Round-robin pointer favours requester 0.
  - FSM in IDLE.
- FSM states: IDLE -> LOAD -> SHIFT -> DONE -> IDLE.
- IDLE:
  - Samples req0/req1.
  - If exactly one is high, grant it.
  - If both are high, grant the requester indicated by the pointer.
  - If neither is high, stay in IDLE.
- LOAD (one cycle):
  - Capture the granted val into the shift register; clear the 16-bit BCD register.
  - Pulse the matching ack; record the grantee.
  - Toggle the pointer to favour the other requester. The pointer changes only on a grant.
- SHIFT (exactly WIDTH cycles, counter 0..WIDTH-1):
  - Each cycle, first add 3 to every BCD nibble that is >= 5.
  - Then shift {bcd, bin} left by one.
- DONE (one cycle):
  - Encode each nibble and register it into display0..3.
  - src = grantee; pulse done.
  - Return to IDLE.
- busy is high in LOAD, SHIFT and DONE.
- Latency:
  - Request seen in IDLE at cycle N: ack at N+1.
  - Displays and done at N+WIDTH+2.
  - Earliest next grant at N+WIDTH+3.
- Requests arriving while busy are ignored until IDLE; no queueing.
- A requester still asserting req after its ack is treated as a fresh request. Round-robin then alternates if both are held.
- val changes after ack have no effect on the current conversion.
- Segment encoding:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1011000, 8=0000000, 9=0010000
  - Any nibble > 9 = 0111111 (unreachable for legal WIDTH).
- Displays hold their last value between conversions.
- rst asserted mid-conversion: abort on that edge; no ack/done pulse afterwards; all outputs return to reset values.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - In DONE, zero digits above the most significant non-zero digit drive 7'b1111111 (all segments off).
  - display0 always shows its digit, so value 0 shows "   0".
  - Blanking is decided per conversion and registered with the digits. Latency is unchanged.
- Undefined: all four digits always shown, including leading zeros, e.g. 42 -> "0042".

Test Plan:
- Reset: rst high 2 cycles -> display0..3 = 0111111; ack0/ack1/busy/done = 0; src = 0.
- Single request: req0=1, val0=426 in IDLE at cycle N -> ack0 at N+1, busy N+1..N+12, done at N+12. Displays: display3=1000000, display2=0011001, display1=0100100, display0=0000010; src=0.
- Contention: req0 and req1 both held, val0=1023, val1=7 -> first grant req0, displays 1,0,2,3. Next grant req1, displays 0,0,0,7 (blanking undefined), src=1. Then req0 again (alternation).
- Ignore while busy: pulse req1 for one cycle at N+5 during a req0 conversion -> no ack1, no second conversion.
- Reset mid-conversion: rst at N+6 -> no done; displays return to dash; next req1 gets ack1 one cycle after it is seen.
- With LEADING_ZERO_BLANK_EN, val0=0 -> display3..1 = 1111111, display0 = 1000000. With val0=50 -> display3/2 blank, display1=0010010, display0=1000000.

Source files
------------

// File: rtl/display_conv_ctrl.sv
// display_conv_ctrl: round-robin arbiter for two value sources that share a
// four-digit seven-segment display. The granted binary value is converted to
// BCD with an iterative shift-add-3 (double dabble) datapath, one bit per clock.
// The converted digits are then registered onto active-low segment outputs.
// Optional feature macro: LEADING_ZERO_BLANK_EN.
// When it is defined, zero digits above the most significant non-zero digit
// are blanked. display0 is never blanked.
module display_conv_ctrl #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] val0,
    input  logic             req1,
    input  logic [WIDTH-1:0] val1,
    output logic             ack0,
    output logic             ack1,
    output logic             busy,
    output logic             done,
    output logic             src,
    output logic [6:0]       display0,
    output logic [6:0]       display1,
    output logic [6:0]       display2,
    output logic [6:0]       display3
);

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] LAST_CNT  = 4'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_t;

    // Active-low {g,f,e,d,c,b,a}; anything outside 0..9 shows a dash
    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1011000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    state_t           state_reg;
    logic             ptr_reg;      // 0: requester 0 wins a tie, 1: requester 1 wins
    logic             grant_reg;
    logic             ack0_reg;
    logic             ack1_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             src_reg;
    logic [WIDTH-1:0] bin_reg;
    logic [15:0]      bcd_reg;
    logic [3:0]       cnt_reg;
    logic [6:0]       display_reg [4];

    logic             grant_sel;
    logic [14:0]      bcd_adj;
    logic [15:0]      bcd_next;
    logic [WIDTH-1:0] bin_next;
    logic [3:0]       digit [4];
    logic [3:0]       blank;
    logic [6:0]       seg_next [4];

    // A tie goes to the pointer; otherwise to whichever requester is asking
    assign grant_sel = (req0 && req1) ? ptr_reg : req1;

    // Add-3 correction on each BCD nibble that is 5 or more
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        bcd_reg[gi*4 +: 4] + 4'd3 :
                                        bcd_reg[gi*4 +: 4];
        end
    endgenerate

    // The thousands nibble loses its top bit in the shift, so only three bits are kept
    assign bcd_adj[14:12] = (bcd_reg[15:12] >= 4'd5) ? bcd_reg[14:12] + 3'd3 :
                                                       bcd_reg[14:12];

    // One left shift of the concatenation {bcd, bin}
    assign bcd_next = {bcd_adj, bin_reg[WIDTH-1]};
    assign bin_next = {bin_reg[WIDTH-2:0], 1'b0};

    // Segment patterns computed from the post-shift BCD, loaded on the final shift
    generate
        for (gi = 0; gi < 4; gi++) begin : g_seg
            assign digit[gi]    = bcd_next[gi*4 +: 4];
            assign seg_next[gi] = blank[gi] ? SEG_BLANK : seg_encode(digit[gi]);
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    // A digit blanks only if it and every digit above it are zero
    assign blank[3] = (digit[3] == 4'd0);
    assign blank[2] = blank[3] && (digit[2] == 4'd0);
    assign blank[1] = blank[2] && (digit[1] == 4'd0);
    assign blank[0] = 1'b0;
`else
    assign blank = 4'b0000;
`endif

    // Control FSM with the conversion datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= 1'b0;
            grant_reg <= 1'b0;
            ack0_reg  <= 1'b0;
            ack1_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            src_reg   <= 1'b0;
            bin_reg   <= '0;
            bcd_reg   <= '0;
            cnt_reg   <= '0;
            for (int i = 0; i < 4; i++) begin
                display_reg[i] <= SEG_DASH;
            end
        end else begin
            ack0_reg <= 1'b0;
            ack1_reg <= 1'b0;
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    // The value is captured on the grant edge, so val may change once ack is seen
                    if (req0 || req1) begin
                        grant_reg <= grant_sel;
                        ptr_reg   <= ~grant_sel;
                        bin_reg   <= grant_sel ? val1 : val0;
                        bcd_reg   <= '0;
                        ack0_reg  <= ~grant_sel;
                        ack1_reg  <= grant_sel;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    cnt_reg   <= '0;
                    state_reg <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    bcd_reg <= bcd_next;
                    bin_reg <= bin_next;
                    cnt_reg <= cnt_reg + 4'd1;
                    if (cnt_reg == LAST_CNT) begin
                        for (int i = 0; i < 4; i++) begin
                            display_reg[i] <= seg_next[i];
                        end
                        src_reg   <= grant_reg;
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack0     = ack0_reg;
    assign ack1     = ack1_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign src      = src_reg;
    assign display0 = display_reg[0];
    assign display1 = display_reg[1];
    assign display2 = display_reg[2];
    assign display3 = display_reg[3];

endmodule

// File: tb/tb_display_conv_ctrl.sv
// tb_display_conv_ctrl: directed stimulus for display_conv_ctrl.
// A transaction-timeline model predicts every output on every cycle.
// Literal expectations pin the model to hand-computed values.
// The optional feature is selected with LEADING_ZERO_BLANK_EN.
module tb_display_conv_ctrl;

    localparam int WIDTH = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0 = 1'b0;
    logic             req1 = 1'b0;
    logic [WIDTH-1:0] val0 = '0;
    logic [WIDTH-1:0] val1 = '0;
    logic             ack0, ack1, busy, done, src;
    logic [6:0]       display0, display1, display2, display3;
    logic [6:0]       disp [4];

    int n_cmp = 0;
    int n_bad = 0;

    display_conv_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .val0     (val0),
        .req1     (req1),
        .val1     (val1),
        .ack0     (ack0),
        .ack1     (ack1),
        .busy     (busy),
        .done     (done),
        .src      (src),
        .display0 (display0),
        .display1 (display1),
        .display2 (display2),
        .display3 (display3)
    );

    assign disp[0] = display0;
    assign disp[1] = display1;
    assign disp[2] = display2;
    assign disp[3] = display3;

    always #5 clk = ~clk;

    localparam logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                        7'b0011001, 7'b0010010, 7'b0000010, 7'b1011000,
                                        7'b0000000, 7'b0010000};
    localparam logic [6:0] DASH = 7'b0111111;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", nm, act, exp);
        end
    endtask

    task automatic chk_disp(input string nm, input logic [6:0] d3, input logic [6:0] d2,
                            input logic [6:0] d1, input logic [6:0] d0);
        chk({nm, "_display3"}, display3, d3);
        chk({nm, "_display2"}, display2, d2);
        chk({nm, "_display1"}, display1, d1);
        chk({nm, "_display0"}, display0, d0);
    endtask

    // Bounded wait for the done pulse; call right after a falling edge
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 60) begin
            @(negedge clk);
            cycles++;
        end
        chk("done_seen", done, 1'b1);
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic winner(input logic r0, input logic r1, input logic p);
        return (r0 && r1) ? p : r1;
    endfunction

    // Segment pattern of decimal digit k of v (k=0 is units)
    function automatic logic [6:0] exp_seg(input int v, input int k);
        int p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
`ifdef LEADING_ZERO_BLANK_EN
        if (k > 0 && v < p) return 7'b1111111;
`endif
        return SEG[(v / p) % 10];
    endfunction

    int         phase;       // 0 = idle, otherwise cycles elapsed since the grant
    int         m_val;
    logic       m_ptr, m_grant, model_on = 1'b0;
    logic       exp_ack0, exp_ack1, exp_busy, exp_done, exp_src;
    logic [6:0] exp_disp [4];

    always @(posedge clk) begin
        if (rst) begin
            phase    <= 0;
            m_val    <= 0;
            m_ptr    <= 1'b0;
            m_grant  <= 1'b0;
            exp_ack0 <= 1'b0;
            exp_ack1 <= 1'b0;
            exp_busy <= 1'b0;
            exp_done <= 1'b0;
            exp_src  <= 1'b0;
            for (int k = 0; k < 4; k++) exp_disp[k] <= DASH;
            model_on <= 1'b1;
        end else begin
            exp_ack0 <= 1'b0;
            exp_ack1 <= 1'b0;
            exp_done <= 1'b0;
            if (phase == 0) begin
                if (req0 || req1) begin
                    m_grant  <= winner(req0, req1, m_ptr);
                    m_ptr    <= !winner(req0, req1, m_ptr);
                    m_val    <= winner(req0, req1, m_ptr) ? int'(val1) : int'(val0);
                    exp_ack0 <= !winner(req0, req1, m_ptr);
                    exp_ack1 <= winner(req0, req1, m_ptr);
                    exp_busy <= 1'b1;
                    phase    <= 1;
                end
            end else if (phase == WIDTH + 1) begin
                exp_done <= 1'b1;
                exp_src  <= m_grant;
                for (int k = 0; k < 4; k++) exp_disp[k] <= exp_seg(m_val, k);
                phase <= phase + 1;
            end else if (phase == WIDTH + 2) begin
                exp_busy <= 1'b0;
                phase    <= 0;
            end else begin
                phase <= phase + 1;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (model_on) begin
            chk("model_ack0", ack0, exp_ack0);
            chk("model_ack1", ack1, exp_ack1);
            chk("model_busy", busy, exp_busy);
            chk("model_done", done, exp_done);
            chk("model_src", src, exp_src);
            for (int k = 0; k < 4; k++)
                chk($sformatf("model_display%0d", k), disp[k], exp_disp[k]);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end of stimulus");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int c;

        // Reset for two cycles
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_disp("reset", DASH, DASH, DASH, DASH);
        chk("reset_ack0", ack0, 1'b0);
        chk("reset_ack1", ack1, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_src", src, 1'b0);
        rst = 1'b0;

        // Single request 426, with a stray req1 pulse at N+5
        @(negedge clk);
        req0 = 1'b1; val0 = 10'd426;
        @(negedge clk);                          // N+1
        chk("t1_ack0", ack0, 1'b1);
        chk("t1_busy", busy, 1'b1);
        req0 = 1'b0; val0 = '1;                  // change after ack must not matter
        repeat (4) @(negedge clk);               // N+5
        req1 = 1'b1; val1 = 10'd3;
        @(negedge clk);                          // N+6
        req1 = 1'b0;
        wait_done(c);
        chk("t1_latency", c, WIDTH - 4);         // done at N+12
        chk_disp("t1", 7'b1000000, 7'b0011001, 7'b0100100, 7'b0000010);
        chk("t1_src", src, 1'b0);
        repeat (3) @(negedge clk);
        chk("t1_no_second", busy, 1'b0);

        // Contention from reset: 0, 1, 0
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req0 = 1'b1; req1 = 1'b1; val0 = 10'd1023; val1 = 10'd7;
        @(negedge clk);
        chk("t2_first_ack0", ack0, 1'b1);
        chk("t2_first_ack1", ack1, 1'b0);
        wait_done(c);
        chk("t2_first_src", src, 1'b0);
        chk_disp("t2_first", 7'b1111001, 7'b1000000, 7'b0100100, 7'b0110000);
        @(negedge clk);
        wait_done(c);
        chk("t2_gap", c + 1, WIDTH + 3);
        chk("t2_second_src", src, 1'b1);
`ifdef LEADING_ZERO_BLANK_EN
        chk_disp("t2_second", 7'b1111111, 7'b1111111, 7'b1111111, 7'b1011000);
`else
        chk_disp("t2_second", 7'b1000000, 7'b1000000, 7'b1000000, 7'b1011000);
`endif
        @(negedge clk);
        wait_done(c);
        chk("t2_third_src", src, 1'b0);
        chk_disp("t2_third", 7'b1111001, 7'b1000000, 7'b0100100, 7'b0110000);
        req0 = 1'b0; req1 = 1'b0;

        // Reset mid-conversion, then a fresh req1
        @(negedge clk);
        req0 = 1'b1; val0 = 10'd555;
        @(negedge clk);                          // N+1
        chk("t3_ack0", ack0, 1'b1);
        req0 = 1'b0;
        repeat (5) @(negedge clk);               // N+6
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t3_busy_cleared", busy, 1'b0);
        chk("t3_no_done", done, 1'b0);
        chk_disp("t3_dash", DASH, DASH, DASH, DASH);
        req1 = 1'b1; val1 = 10'd99;
        @(negedge clk);
        chk("t3_ack1", ack1, 1'b1);
        req1 = 1'b0;
        wait_done(c);
        chk("t3_src", src, 1'b1);
`ifdef LEADING_ZERO_BLANK_EN
        chk_disp("t3_99", 7'b1111111, 7'b1111111, 7'b0010000, 7'b0010000);
`else
        chk_disp("t3_99", 7'b1000000, 7'b1000000, 7'b0010000, 7'b0010000);
`endif

        // Value 0
        @(negedge clk);
        req0 = 1'b1; val0 = 10'd0;
        @(negedge clk);
        req0 = 1'b0;
        wait_done(c);
`ifdef LEADING_ZERO_BLANK_EN
        chk_disp("t4_zero", 7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000);
`else
        chk_disp("t4_zero", 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);
`endif

        // Value 50
        @(negedge clk);
        req0 = 1'b1; val0 = 10'd50;
        @(negedge clk);
        req0 = 1'b0;
        wait_done(c);
`ifdef LEADING_ZERO_BLANK_EN
        chk_disp("t5_fifty", 7'b1111111, 7'b1111111, 7'b0010010, 7'b1000000);
`else
        chk_disp("t5_fifty", 7'b1000000, 7'b1000000, 7'b0010010, 7'b1000000);
`endif
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
